pito_prog_loader: RTL
=====================

Name: pito_prog_loader

Overview:
- Byte-stream program loader feeding the SoC external memory-programming port (imem/dmem write side).
- Consumes framed bytes from the UART receiver and assembles 32-bit little-endian words.
- Issues single-cycle write requests into instruction or data memory.
- Holds pito_program high while a frame is in flight, so the harts stay parked during loading.

Parameters:
- IMEM_ADDR_W, 12, word-address width of instruction memory.
- DMEM_ADDR_W, 12, word-address width of data memory.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte this cycle
- imem_wdata  out  32  write word
- imem_addr  out  IMEM_ADDR_W  word address
- imem_req  out  1  write request, single-cycle pulse
- imem_we  out  1  write enable, equals imem_req
- imem_be  out  4  byte enables, 4'hF when imem_req, else 0
- dmem_wdata / dmem_addr(DMEM_ADDR_W) / dmem_req / dmem_we / dmem_be  out  same semantics for data memory
- pito_program  out  1  high from CMD accept through DONE
- load_done  out  1  one-cycle pulse, frame completed OK
- load_err  out  1  one-cycle pulse, frame aborted

Behaviour:
- Byte accept: a byte transfers when rx_valid && rx_ready. rx_ready is 1 in all states except WRITE and DONE.
- Frame layout: SYNC, CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then LEN×4 data bytes (LSB first per word).
- CMD: bit0 selects target (0=imem, 1=dmem). Bits 7:1 must be 0.
- ADDR and LEN are 16-bit word values. ADDR is truncated to the target address width.
- FSM: IDLE -> CMD -> ADDR0 -> ADDR1 -> LEN0 -> LEN1 -> DATA <-> WRITE -> (CSUM) -> DONE -> IDLE.
- IDLE: non-SYNC bytes are consumed and discarded. SYNC moves to CMD.
- CMD with bits 7:1 nonzero: load_err pulse, return to IDLE, no writes issued.
- LEN1 with LEN=0: go straight to CSUM (if enabled) or DONE.
- DATA: collects 4 bytes via a 2-bit byte counter, then moves to WRITE.
- WRITE (exactly 1 cycle):
  - Target req/we=1, be=4'hF, wdata=assembled word, addr=current pointer.
  - Pointer increments modulo 2^ADDR_W; it wraps silently, with no error.
  - Remaining count decrements. Next state is DATA if count≠0, else CSUM/DONE.
- Write throughput: one write per 4 accepted bytes. Write latency: the write occurs in the cycle after the 4th byte is accepted.
- DONE (1 cycle): load_done=1, rx_ready=0, then IDLE.
- pito_program: high in states CMD through DONE inclusive, low in IDLE. It drops in the cycle after DONE.
- Only one of imem_req/dmem_req is ever high. The inactive port drives req/we/be=0 and holds its wdata/addr.
- A SYNC byte received mid-frame is treated as data; there is no resynchronisation.
- Reset (async, any state, including mid-frame):
  - FSM to IDLE.
  - All req/we/be, pito_program, load_done, load_err = 0.
  - wdata/addr = 0, counters = 0.
  - Partially received words are discarded; no write is issued.

Optional Feature:
- Macro: PITO_PROG_LOADER_CSUM_EN.
- Defined:
  - After the last data byte (or after LEN1 when LEN=0), state CSUM expects one byte equal to the XOR of every byte from CMD through the last data byte.
  - Match: go to DONE.
  - Mismatch: load_err pulse, return to IDLE. Writes already issued are not rolled back.
- Undefined: CSUM state and XOR accumulator are absent; the last write goes directly to DONE.

Decomposition:
- pito_pkg:
  - loader_state_e enum.
  - Constants LOADER_SYNC=8'hA5, LOADER_TGT_IMEM=1'b0, LOADER_TGT_DMEM=1'b1.
  - Header field widths.
- Sub-module pito_word_assembler:
  - Shift register, byte counter and word_valid strobe.
  - Takes byte+accept in, produces 32-bit word out.
  - Includes the optional XOR accumulator.

Test Plan:
- A5 00 10 00 02 00 | 78 56 34 12 | EF BE AD DE -> imem writes @0x010=0x12345678, @0x011=0xDEADBEEF, each req exactly 1 cycle; load_done pulse; pito_program high CMD..DONE.
- A5 01 FF 0F 02 00 + 8 data bytes, DMEM_ADDR_W=12 -> dmem writes @0xFFF then @0x000 (wrap); imem_req never asserted.
- Garbage 00 FF 3C, then A5 80 -> first 3 bytes dropped; load_err pulse on CMD; no req; pito_program back to 0.
- rx_valid toggled randomly during the data phase -> identical write sequence; rx_ready=0 in every WRITE/DONE cycle.
- rst asserted after 2 data bytes of a 1-word frame -> immediate outputs 0, no write; a subsequent clean frame loads correctly.
- CSUM_EN: A5 00 00 00 01 00 01 02 03 04 csum=0x05 -> write 0x04030201 + load_done. Same frame with csum=0x06 -> write still issued, then load_err, no load_done.

Source files
------------

// File: rtl/pito_pkg.sv
// pito_pkg: shared types and constants for the pito program loader.
//   loader_state_e   - loader FSM state encoding
//   LOADER_SYNC      - default frame start marker
//   LOADER_TGT_*     - CMD bit0 target select values
//   LOADER_HDR_*_W   - header field widths (ADDR and LEN are 16-bit word values)
// Optional feature macro: PITO_PROG_LOADER_CSUM_EN adds the CSUM state.
package pito_pkg;

  localparam logic [7:0] LOADER_SYNC     = 8'hA5;
  localparam logic       LOADER_TGT_IMEM = 1'b0;
  localparam logic       LOADER_TGT_DMEM = 1'b1;

  localparam int LOADER_HDR_ADDR_W = 16;
  localparam int LOADER_HDR_LEN_W  = 16;
  localparam int LOADER_WORD_W     = 32;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CMD   = 4'd1,
    ST_ADDR0 = 4'd2,
    ST_ADDR1 = 4'd3,
    ST_LEN0  = 4'd4,
    ST_LEN1  = 4'd5,
    ST_DATA  = 4'd6,
    ST_WRITE = 4'd7,
`ifdef PITO_PROG_LOADER_CSUM_EN
    ST_CSUM  = 4'd8,
`endif
    ST_DONE  = 4'd9
  } loader_state_e;

endpackage

// File: rtl/pito_word_assembler.sv
// pito_word_assembler: collects data bytes LSB-first into 32-bit words.
//   clk, rst      - core clock, async active-high reset
//   clear_i       - drop any partial word and restart the byte counter
//   data_en_i     - byte_i is an accepted data byte
//   byte_i        - incoming byte
//   word_next_o   - word including byte_i, valid when word_done_o is high
//   word_done_o   - this accepted byte completes a word
//   xor_en_i      - (PITO_PROG_LOADER_CSUM_EN) fold byte_i into checksum
//   csum_o        - (PITO_PROG_LOADER_CSUM_EN) running XOR of folded bytes
module pito_word_assembler
  import pito_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     data_en_i,
  input  logic [7:0]               byte_i,
`ifdef PITO_PROG_LOADER_CSUM_EN
  input  logic                     xor_en_i,
  output logic [7:0]               csum_o,
`endif
  output logic [LOADER_WORD_W-1:0] word_next_o,
  output logic                     word_done_o
);

  logic [LOADER_WORD_W-1:0] shift_q, shift_d;
  logic [1:0]               cnt_q, cnt_d;

  // Bytes enter at the top so after four shifts the first byte sits in [7:0].
  assign word_next_o = {byte_i, shift_q[LOADER_WORD_W-1:8]};
  assign word_done_o = data_en_i && (cnt_q == 2'd3);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = 2'd0;
    end else if (data_en_i) begin
      shift_d = word_next_o;
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PITO_PROG_LOADER_CSUM_EN
  logic [7:0] acc_q, acc_d;

  assign csum_o = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clear_i)       acc_d = 8'h00;
    else if (xor_en_i) acc_d = acc_q ^ byte_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= 8'h00;
    else     acc_q <= acc_d;
  end
`endif

endmodule

// File: rtl/pito_prog_loader.sv
// pito_prog_loader: framed byte stream -> imem/dmem single-cycle word writes.
//   clk, rst                 - core clock, async active-high reset
//   rx_data/rx_valid/rx_ready- byte input handshake
//   imem_* / dmem_*          - write ports (req/we pulse, be=F on write)
//   pito_program             - high while a frame is in flight (CMD..DONE)
//   load_done / load_err     - one-cycle completion / abort pulses
// Optional feature macro: PITO_PROG_LOADER_CSUM_EN (trailing XOR checksum byte).
//
// state | meaning
// IDLE  | discard bytes until SYNC
// CMD   | target select byte, bits 7:1 must be zero
// ADDR0 | start word address, low byte
// ADDR1 | start word address, high byte
// LEN0  | word count, low byte
// LEN1  | word count, high byte (zero skips data)
// DATA  | collecting the four bytes of a word
// WRITE | write pulse on the target port, pointer/count advance
// CSUM  | checksum byte compare (optional)
// DONE  | load_done pulse, input stalled
module pito_prog_loader
  import pito_pkg::*;
#(
  parameter int         IMEM_ADDR_W = 12,
  parameter int         DMEM_ADDR_W = 12,
  parameter logic [7:0] SYNC_BYTE   = LOADER_SYNC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [31:0]            imem_wdata,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic                   imem_req,
  output logic                   imem_we,
  output logic [3:0]             imem_be,
  output logic [31:0]            dmem_wdata,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [3:0]             dmem_be,
  output logic                   pito_program,
  output logic                   load_done,
  output logic                   load_err
);

  // One pointer wide enough for either target; each port takes its low bits,
  // so wrapping at the wider width still wraps the narrower one correctly.
  localparam int PTR_W = (IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W;

`ifdef PITO_PROG_LOADER_CSUM_EN
  localparam loader_state_e ST_AFTER_DATA = ST_CSUM;
`else
  localparam loader_state_e ST_AFTER_DATA = ST_DONE;
`endif

  loader_state_e                state_q, state_d;
  logic                         tgt_q, tgt_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [LOADER_HDR_LEN_W-1:0]  cnt_q, cnt_d;

  logic                   rx_ready_q, rx_ready_d;
  logic [31:0]            imem_wdata_q, imem_wdata_d;
  logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic                   imem_req_q, imem_req_d;
  logic [31:0]            dmem_wdata_q, dmem_wdata_d;
  logic [DMEM_ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic                   dmem_req_q, dmem_req_d;
  logic                   pito_program_q, pito_program_d;
  logic                   load_done_q, load_done_d;
  logic                   load_err_q, load_err_d;

  logic        accept;
  logic        asm_clear, asm_data_en;
  logic [31:0] word_next;
  logic        word_done;
`ifdef PITO_PROG_LOADER_CSUM_EN
  logic        asm_xor_en;
  logic [7:0]  csum;
`endif

  assign accept = rx_valid && rx_ready_q;

  pito_word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (asm_clear),
    .data_en_i   (asm_data_en),
    .byte_i      (rx_data),
`ifdef PITO_PROG_LOADER_CSUM_EN
    .xor_en_i    (asm_xor_en),
    .csum_o      (csum),
`endif
    .word_next_o (word_next),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    imem_wdata_d = imem_wdata_q;
    imem_addr_d  = imem_addr_q;
    imem_req_d   = 1'b0;
    dmem_wdata_d = dmem_wdata_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_req_d   = 1'b0;
    load_err_d   = 1'b0;
    asm_clear    = 1'b0;
    asm_data_en  = 1'b0;
`ifdef PITO_PROG_LOADER_CSUM_EN
    asm_xor_en   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        asm_clear = 1'b1;
        if (accept && rx_data == SYNC_BYTE) state_d = ST_CMD;
      end
      ST_CMD: if (accept) begin
`ifdef PITO_PROG_LOADER_CSUM_EN
        asm_xor_en = 1'b1;
`endif
        if (rx_data[7:1] != 7'd0) begin
          load_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tgt_d   = rx_data[0];
          state_d = ST_ADDR0;
        end
      end
      ST_ADDR0: if (accept) begin
`ifdef PITO_PROG_LOADER_CSUM_EN
        asm_xor_en = 1'b1;
`endif
        ptr_d   = PTR_W'({rx_data, rx_data});
        state_d = ST_ADDR1;
      end
      ST_ADDR1: if (accept) begin
`ifdef PITO_PROG_LOADER_CSUM_EN
        asm_xor_en = 1'b1;
`endif
        // Truncation to the target width happens here; upper ADDR bits are ignored.
        ptr_d   = PTR_W'({rx_data, ptr_q[7:0]});
        state_d = ST_LEN0;
      end
      ST_LEN0: if (accept) begin
`ifdef PITO_PROG_LOADER_CSUM_EN
        asm_xor_en = 1'b1;
`endif
        cnt_d   = {8'h00, rx_data};
        state_d = ST_LEN1;
      end
      ST_LEN1: if (accept) begin
`ifdef PITO_PROG_LOADER_CSUM_EN
        asm_xor_en = 1'b1;
`endif
        cnt_d   = {rx_data, cnt_q[7:0]};
        state_d = ({rx_data, cnt_q[7:0]} == 16'd0) ? ST_AFTER_DATA : ST_DATA;
      end
      ST_DATA: if (accept) begin
`ifdef PITO_PROG_LOADER_CSUM_EN
        asm_xor_en = 1'b1;
`endif
        asm_data_en = 1'b1;
        // Write outputs are registered, so they are loaded on the 4th byte and
        // appear during the WRITE cycle that follows.
        if (word_done) begin
          state_d = ST_WRITE;
          if (tgt_q == LOADER_TGT_IMEM) begin
            imem_req_d   = 1'b1;
            imem_wdata_d = word_next;
            imem_addr_d  = ptr_q[IMEM_ADDR_W-1:0];
          end else begin
            dmem_req_d   = 1'b1;
            dmem_wdata_d = word_next;
            dmem_addr_d  = ptr_q[DMEM_ADDR_W-1:0];
          end
        end
      end
      ST_WRITE: begin
        ptr_d   = ptr_q + PTR_W'(1);
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q != 16'd1) ? ST_DATA : ST_AFTER_DATA;
      end
`ifdef PITO_PROG_LOADER_CSUM_EN
      ST_CSUM: if (accept) begin
        if (rx_data == csum) begin
          state_d = ST_DONE;
        end else begin
          load_err_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    rx_ready_d     = !(state_d == ST_WRITE || state_d == ST_DONE);
    pito_program_d = (state_d != ST_IDLE);
    load_done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      tgt_q          <= LOADER_TGT_IMEM;
      ptr_q          <= '0;
      cnt_q          <= '0;
      rx_ready_q     <= 1'b1;
      imem_wdata_q   <= '0;
      imem_addr_q    <= '0;
      imem_req_q     <= 1'b0;
      dmem_wdata_q   <= '0;
      dmem_addr_q    <= '0;
      dmem_req_q     <= 1'b0;
      pito_program_q <= 1'b0;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      tgt_q          <= tgt_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      rx_ready_q     <= rx_ready_d;
      imem_wdata_q   <= imem_wdata_d;
      imem_addr_q    <= imem_addr_d;
      imem_req_q     <= imem_req_d;
      dmem_wdata_q   <= dmem_wdata_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_req_q     <= dmem_req_d;
      pito_program_q <= pito_program_d;
      load_done_q    <= load_done_d;
      load_err_q     <= load_err_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_wdata   = imem_wdata_q;
  assign imem_addr    = imem_addr_q;
  assign imem_req     = imem_req_q;
  assign imem_we      = imem_req_q;
  assign imem_be      = {4{imem_req_q}};
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_req_q;
  assign dmem_be      = {4{dmem_req_q}};
  assign pito_program = pito_program_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;

endmodule
